flux_acq: RTL and testbench
===========================

FLUX_ACQ -- requirements
Module: flux_acq

Interface
REQ-001 The block SHALL have these parameters:
- TIMER_WIDTH, default 7, flux interval counter width (legal 4..15).
- STOP_WIDTH, default 4, width of STOP_COUNT and the index edge counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK, in, 1, acquisition clock.
- ResetTimer, in, 1, asynchronous active-high reset.
- RUN, in, 1, acquisition enable; level-sensitive.
- START_MODE, in, 1, start trigger: 0 = immediate, 1 = wait for index rising edge.
- STOP_COUNT, in, STOP_WIDTH, index rising edges to capture before stopping; 0 = run until RUN low.
- FD_RDDATA_IN, in, 1, raw flux transition pulse, asynchronous.
- FD_INDEX_IN, in, 1, raw index pulse, asynchronous.
- RAM_FULL, in, 1, acquisition RAM cannot accept a write this cycle.
- DATA, out, TIMER_WIDTH+1, record: MSB = synchronised index level; low bits = interval, or 0 for an overflow marker.
- WRITE, out, 1, one-cycle RAM write strobe qualifying DATA.
- BUSY, out, 1, high in ARM or ACQ.
- DONE, out, 1, high in DONE.
- OVERRUN, out, 1, sticky flag: a record was dropped because RAM_FULL was high.

REQ-003 Clock SHALL be CLOCK; reset SHALL be ResetTimer, asynchronous, active-high.

Function
REQ-004 FD_RDDATA_IN and FD_INDEX_IN SHALL each pass through a synchroniser, then a registered previous-value flop; rise = sync AND NOT prev.
REQ-005 One flux pulse of any width SHALL produce at most one record (rising edge only).
REQ-006 FSM states SHALL be IDLE, ARM, ACQ and DONE. RUN low SHALL force IDLE on the next edge from any state and take precedence over all other transitions.
REQ-007 IDLE with RUN high SHALL go to ACQ if START_MODE=0, or to ARM if START_MODE=1. Leaving IDLE SHALL clear OVERRUN and the index counter.
REQ-008 ARM SHALL go to ACQ on an index rise; this arming edge SHALL NOT be counted. No WRITE SHALL occur in ARM.
REQ-009 The timer SHALL load 1 on ACQ entry. In each ACQ cycle it SHALL load 1 on an event (flux rise or timer at all-ones), else increment.
REQ-010 On a flux rise in ACQ, DATA SHALL register {index_sync, timer} and WRITE SHALL pulse high for one cycle.
REQ-011 On timer all-ones with no flux rise, DATA SHALL register {index_sync, 0} with a WRITE pulse.
REQ-012 If a flux rise and timer all-ones coincide, exactly one record SHALL be written, carrying value all-ones; no overflow marker SHALL be written.
REQ-013 Records SHALL be possible on consecutive cycles; no flux edge SHALL be lost while in ACQ.
REQ-014 If RAM_FULL is high in a cycle that would write, WRITE SHALL stay 0, OVERRUN SHALL set, and the FSM SHALL go to DONE.
REQ-015 Each index rise in ACQ SHALL increment the index counter. When STOP_COUNT≠0 and the counter reaches STOP_COUNT, the FSM SHALL go to DONE; a record due in that same cycle SHALL still be written.
REQ-016 DONE SHALL hold, with WRITE=0, until RUN goes low. OVERRUN SHALL remain valid in DONE and in the following IDLE.
REQ-017 Latency: FD_RDDATA_IN sampled high at edge N SHALL give WRITE high after edge N+1 (single-flop synchroniser) or N+2 (double-flop synchroniser).
REQ-018 DATA SHALL hold its last value when WRITE is 0.

Reset
REQ-019 On ResetTimer high, asynchronously: state=IDLE, DATA=0, WRITE=0, BUSY=0, DONE=0, OVERRUN=0, timer=1, index counter=0, all synchroniser and edge flops=0.
REQ-020 ResetTimer asserted mid-acquisition SHALL discard any in-flight record; no WRITE pulse SHALL follow deassertion until a new start from IDLE.

Configuration
REQ-021 When FLUX_ACQ_DSYNC_EN is defined, each input SHALL use a two-flop synchroniser; when undefined, a single flop. All other behaviour is identical apart from the latency in REQ-017.

Verification (TIMER_WIDTH=7, macro undefined)
REQ-022 RUN=1, START_MODE=0, 1-cycle flux pulses every 10 cycles, index low -> steady-state records 0x0A, one WRITE per pulse.
REQ-023 Same setup with 3-cycle-wide flux pulses every 10 cycles -> records still 0x0A, exactly one WRITE per pulse.
REQ-024 No flux for 300 cycles after ACQ entry, index high -> records 0x80 at cycles 127 and 254 after entry.
REQ-025 Flux pulse landing on the timer=127 cycle -> single record 0x7F, no 0x00 record.
REQ-026 START_MODE=1, STOP_COUNT=2, index pulses at 1000-cycle spacing -> no WRITE before the first index edge, DONE=1 on the third index edge, WRITE=0 thereafter.
REQ-027 RAM_FULL=1 on the third record -> WRITE=0 that cycle, OVERRUN=1, DONE=1; RUN low then high -> OVERRUN=0, BUSY=1.

Source files
------------

// File: rtl/flux_acq.sv
// rtl/flux_acq.sv - flux interval acquisition into RAM records; FLUX_ACQ_DSYNC_EN selects two-flop input synchronisers.
module flux_acq #(
    parameter int TIMER_WIDTH = 7,
    parameter int STOP_WIDTH  = 4
) (
    input  logic                   CLOCK,
    input  logic                   ResetTimer,
    input  logic                   RUN,
    input  logic                   START_MODE,
    input  logic [STOP_WIDTH-1:0]  STOP_COUNT,
    input  logic                   FD_RDDATA_IN,
    input  logic                   FD_INDEX_IN,
    input  logic                   RAM_FULL,
    output logic [TIMER_WIDTH:0]   DATA,
    output logic                   WRITE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERRUN
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_ACQ, ST_DONE} state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

    state_t                  state, state_next;
    logic [TIMER_WIDTH-1:0]  timer;
    logic [STOP_WIDTH-1:0]   index_cnt;
    logic [STOP_WIDTH-1:0]   index_cnt_inc;
    logic                    flux_sync, index_sync;
    logic                    flux_prev, index_prev;
    logic                    flux_rise, index_rise;
    logic                    rec_due, write_next, overrun_set, leave_idle, stop_hit;

`ifdef FLUX_ACQ_DSYNC_EN
    logic [1:0] flux_meta, index_meta;

    always_ff @(posedge CLOCK or posedge ResetTimer) begin
        if (ResetTimer) begin
            flux_meta  <= '0;
            index_meta <= '0;
        end else begin
            flux_meta  <= {flux_meta[0], FD_RDDATA_IN};
            index_meta <= {index_meta[0], FD_INDEX_IN};
        end
    end

    assign flux_sync  = flux_meta[1];
    assign index_sync = index_meta[1];
`else
    logic flux_meta, index_meta;

    always_ff @(posedge CLOCK or posedge ResetTimer) begin
        if (ResetTimer) begin
            flux_meta  <= 1'b0;
            index_meta <= 1'b0;
        end else begin
            flux_meta  <= FD_RDDATA_IN;
            index_meta <= FD_INDEX_IN;
        end
    end

    assign flux_sync  = flux_meta;
    assign index_sync = index_meta;
`endif

    always_ff @(posedge CLOCK or posedge ResetTimer) begin
        if (ResetTimer) begin
            flux_prev  <= 1'b0;
            index_prev <= 1'b0;
        end else begin
            flux_prev  <= flux_sync;
            index_prev <= index_sync;
        end
    end

    assign flux_rise     = flux_sync & ~flux_prev;
    assign index_rise    = index_sync & ~index_prev;
    assign index_cnt_inc = index_cnt + STOP_WIDTH'(1);

    // A flux edge coinciding with timer overflow yields one record carrying the full interval.
    always_comb begin
        state_next  = state;
        rec_due     = (state == ST_ACQ) && (flux_rise || (timer == TIMER_MAX));
        stop_hit    = index_rise && (STOP_COUNT != '0) && (index_cnt_inc == STOP_COUNT);
        write_next  = RUN && rec_due && !RAM_FULL;
        overrun_set = RUN && rec_due && RAM_FULL;
        leave_idle  = RUN && (state == ST_IDLE);
        if (!RUN) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = START_MODE ? ST_ARM : ST_ACQ;
                ST_ARM:  if (index_rise) state_next = ST_ACQ;
                ST_ACQ:  if (overrun_set || stop_hit) state_next = ST_DONE;
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge ResetTimer) begin
        if (ResetTimer) begin
            state     <= ST_IDLE;
            DATA      <= '0;
            WRITE     <= 1'b0;
            OVERRUN   <= 1'b0;
            timer     <= TIMER_ONE;
            index_cnt <= '0;
        end else begin
            state <= state_next;
            WRITE <= write_next;
            if (write_next) begin
                DATA <= {index_sync, flux_rise ? timer : '0};
            end
            // Held at one outside ACQ so ACQ entry always starts counting from one.
            if ((state != ST_ACQ) || rec_due) begin
                timer <= TIMER_ONE;
            end else begin
                timer <= timer + TIMER_ONE;
            end
            if (leave_idle) begin
                index_cnt <= '0;
            end else if (RUN && (state == ST_ACQ) && index_rise) begin
                index_cnt <= index_cnt_inc;
            end
            if (leave_idle) begin
                OVERRUN <= 1'b0;
            end else if (overrun_set) begin
                OVERRUN <= 1'b1;
            end
        end
    end

    assign BUSY = (state == ST_ARM) || (state == ST_ACQ);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_flux_acq.sv
// tb/tb_flux_acq.sv - randomized and directed checks of flux_acq against an interval-based reference model.
module tb_flux_acq;

    localparam int M_IDLE = 0, M_ARM = 1, M_ACQ = 2, M_DONE = 3;
`ifdef FLUX_ACQ_DSYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic       CLOCK = 1'b0;
    logic       ResetTimer = 1'b1;
    logic       RUN = 1'b0;
    logic       START_MODE = 1'b0;
    logic [3:0] STOP_COUNT = 4'd0;
    logic       FD_RDDATA_IN = 1'b0;
    logic       FD_INDEX_IN = 1'b0;
    logic       RAM_FULL = 1'b0;
    logic [7:0] DATA;
    logic       WRITE, BUSY, DONE, OVERRUN;

    flux_acq #(.TIMER_WIDTH(7), .STOP_WIDTH(4)) dut (
        .CLOCK(CLOCK), .ResetTimer(ResetTimer), .RUN(RUN), .START_MODE(START_MODE),
        .STOP_COUNT(STOP_COUNT), .FD_RDDATA_IN(FD_RDDATA_IN), .FD_INDEX_IN(FD_INDEX_IN),
        .RAM_FULL(RAM_FULL), .DATA(DATA), .WRITE(WRITE), .BUSY(BUSY), .DONE(DONE),
        .OVERRUN(OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: interval = edges elapsed since last reload, not a counter register.
    int       m_mode, m_edge, m_last, m_cnt;
    bit       m_overrun, m_write;
    bit [7:0] m_data;
    bit [2:0] f_hist, x_hist;

    int       wr_tally, zero_tally;
    bit [7:0] last_wr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_overrun = 0; m_write = 0; m_data = 8'h00;
        f_hist = 3'b000; x_hist = 3'b000;
    endtask

    task automatic model_edge();
        bit fr, xr, xl;
        int iv;
        fr = (SYNC_LAT == 1) ? (f_hist[0] & ~f_hist[1]) : (f_hist[1] & ~f_hist[2]);
        xr = (SYNC_LAT == 1) ? (x_hist[0] & ~x_hist[1]) : (x_hist[1] & ~x_hist[2]);
        xl = (SYNC_LAT == 1) ? x_hist[0] : x_hist[1];
        m_edge++;
        m_write = 0;
        if (!RUN) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_overrun = 0; m_cnt = 0; m_last = m_edge;
                    m_mode = START_MODE ? M_ARM : M_ACQ;
                end
                M_ARM: if (xr) begin m_mode = M_ACQ; m_last = m_edge; end
                M_ACQ: begin
                    iv = m_edge - m_last;
                    if (fr || iv == 127) begin
                        m_last = m_edge;
                        if (RAM_FULL) begin
                            m_overrun = 1; m_mode = M_DONE;
                        end else begin
                            m_write = 1;
                            m_data = {xl, fr ? 7'(iv) : 7'd0};
                        end
                    end
                    if (xr) begin
                        m_cnt = (m_cnt + 1) % 16;
                        if (STOP_COUNT != 0 && m_cnt == int'(STOP_COUNT)) m_mode = M_DONE;
                    end
                end
                default: ;
            endcase
        end
        f_hist = {f_hist[1:0], FD_RDDATA_IN};
        x_hist = {x_hist[1:0], FD_INDEX_IN};
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
        check_val("write", WRITE, m_write);
        check_val("data", DATA, m_data);
        check_val("busy", BUSY, (m_mode == M_ARM || m_mode == M_ACQ));
        check_val("done", DONE, (m_mode == M_DONE));
        check_val("overrun", OVERRUN, m_overrun);
        if (WRITE) begin
            wr_tally++;
            last_wr = DATA;
            if (DATA[6:0] == 7'd0) zero_tally++;
        end
    endtask

    task automatic do_reset();
        ResetTimer = 1'b1;
        #1;
        model_reset();
        check_val("rst_write", WRITE, 0);
        check_val("rst_data", DATA, 0);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_overrun", OVERRUN, 0);
        @(negedge CLOCK);
        ResetTimer = 1'b0;
    endtask

    task automatic restart(input bit sm, input logic [3:0] stop);
        RUN = 1'b0;
        tick();
        START_MODE = sm; STOP_COUNT = stop; RUN = 1'b1;
    endtask

    initial begin
        int first_wr, second_wr, guard, dens;
        m_edge = 0; m_last = 0;
        wr_tally = 0; zero_tally = 0; last_wr = 8'h00;
        @(negedge CLOCK);
        do_reset();

        // Steady 1-cycle pulses every 10 cycles
        restart(1'b0, 4'd0);
        for (int i = 0; i < 100; i++) begin
            if (i == 40) wr_tally = 0;
            FD_RDDATA_IN = (i % 10 == 0);
            tick();
        end
        check_val("p1_writes", wr_tally, 6);
        check_val("p1_record", last_wr, 8'h0A);

        // 3-cycle-wide pulses every 10 cycles
        restart(1'b0, 4'd0);
        for (int i = 0; i < 100; i++) begin
            if (i == 40) wr_tally = 0;
            FD_RDDATA_IN = (i % 10 < 3);
            tick();
        end
        check_val("p3_writes", wr_tally, 6);
        check_val("p3_record", last_wr, 8'h0A);

        // No flux, index high: overflow markers
        FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b1;
        RUN = 1'b0;
        repeat (3) tick();
        RUN = 1'b1; wr_tally = 0; first_wr = 0; second_wr = 0;
        for (int j = 1; j <= 300; j++) begin
            tick();
            if (WRITE) begin
                if (first_wr == 0) first_wr = j;
                else if (second_wr == 0) second_wr = j;
            end
        end
        check_val("ovf_writes", wr_tally, 2);
        check_val("ovf_record", last_wr, 8'h80);
        check_val("ovf_first_at", first_wr, 128);
        check_val("ovf_second_at", second_wr, 255);

        // Flux edge coincides with timer all-ones
        FD_INDEX_IN = 1'b0;
        restart(1'b0, 4'd0);
        tick();
        guard = 0;
        while ((m_edge - m_last) != (126 - SYNC_LAT) && guard < 300) begin
            tick();
            guard++;
        end
        check_val("coinc_align", (guard < 300), 1);
        wr_tally = 0; zero_tally = 0;
        FD_RDDATA_IN = 1'b1;
        tick();
        FD_RDDATA_IN = 1'b0;
        repeat (5) tick();
        check_val("coinc_writes", wr_tally, 1);
        check_val("coinc_record", last_wr, 8'h7F);
        check_val("coinc_zero", zero_tally, 0);

        // Index-armed start, stop after two counted index edges
        restart(1'b1, 4'd2);
        wr_tally = 0;
        for (int i = 0; i < 2800; i++) begin
            if (i == 500) check_val("arm_nowrite", wr_tally, 0);
            if (i == 2490) check_val("arm_notdone", DONE, 0);
            if (i == 2510) begin
                check_val("arm_done", DONE, 1);
                wr_tally = 0;
            end
            FD_RDDATA_IN = (i % 10 == 0);
            FD_INDEX_IN = (i >= 500) && ((i - 500) % 1000 < 4);
            tick();
        end
        check_val("arm_after_done", wr_tally, 0);

        // RAM full on the third record
        FD_INDEX_IN = 1'b0;
        restart(1'b0, 4'd0);
        wr_tally = 0;
        for (int i = 0; i < 100; i++) begin
            FD_RDDATA_IN = (i % 10 == 0);
            if (wr_tally >= 2) RAM_FULL = 1'b1;
            tick();
        end
        check_val("full_writes", wr_tally, 2);
        check_val("full_overrun", OVERRUN, 1);
        check_val("full_done", DONE, 1);
        RAM_FULL = 1'b0; RUN = 1'b0;
        tick();
        check_val("full_idle_overrun", OVERRUN, 1);
        RUN = 1'b1;
        tick();
        check_val("full_restart_overrun", OVERRUN, 0);
        check_val("full_restart_busy", BUSY, 1);

        // Reset with a flux edge in flight
        restart(1'b0, 4'd0);
        repeat (20) tick();
        FD_RDDATA_IN = 1'b1;
        tick();
        do_reset();
        RUN = 1'b0; wr_tally = 0;
        for (int i = 0; i < 10; i++) begin
            FD_RDDATA_IN = i[0];
            tick();
        end
        check_val("rst_nowrite", wr_tally, 0);

        // Randomized run
        dens = 2;
        RUN = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(0, 8);
            FD_RDDATA_IN = ($urandom_range(0, (1 << dens) - 1) == 0);
            if ($urandom_range(0, 39) == 0) FD_INDEX_IN = ~FD_INDEX_IN;
            RAM_FULL = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) START_MODE = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0) STOP_COUNT = 4'($urandom_range(0, 3));
            RUN = ($urandom_range(0, 299) != 0) || (i < 5);
            if ($urandom_range(0, 999) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
